// File: rtl/plot_framebuffer.sv
// plot_framebuffer: captures the fillscreen plot stream into an on-chip
// WIDTH x HEIGHT frame store, counts accepted and clipped plots, and offers
// a one-cycle-latency read port with write-first bypass.
//
// Handshake: there is no backpressure. vga_plot is a one-cycle strobe and
// is accepted every cycle it is high. rd_en is a one-cycle request.
// rd_valid answers it exactly one cycle later and is low otherwise.
// rd_colour holds its last value while rd_valid is low.
module plot_framebuffer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    vga_x,
    input  logic [6:0]    vga_y,
    input  logic [CW-1:0] vga_colour,
    input  logic          vga_plot,
    input  logic          rd_en,
    input  logic [7:0]    rd_x,
    input  logic [6:0]    rd_y,
    output logic [CW-1:0] rd_colour,
    output logic          rd_valid,
    input  logic          clr_cnt,
    output logic [14:0]   plot_count,
    output logic [7:0]    clip_count,
    output logic          frame_done
);

    localparam int          DEPTH        = WIDTH * HEIGHT;
    localparam logic [8:0]  X_LIM        = 9'(WIDTH);
    localparam logic [7:0]  Y_LIM        = 8'(HEIGHT);
    localparam logic [14:0] FRAME_PIXELS = 15'(DEPTH);
    localparam logic [14:0] PLOT_MAX     = 15'h7fff;
    localparam logic [7:0]  CLIP_MAX     = 8'hff;

    // Row-major pixel address; the 160-wide case uses shift-add instead of a multiplier.
    function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        logic [14:0] y15;
        y15 = {8'd0, y};
        if (WIDTH == 160)
            return (y15 << 7) + (y15 << 5) + {7'd0, x};
        else
            return 15'(y15 * 15'(WIDTH)) + {7'd0, x};
    endfunction

    logic [CW-1:0] mem [0:DEPTH-1];

    logic          plot_in_range;
    logic          plot_accept;
    logic          plot_clip;
    logic [14:0]   plot_addr;
    logic          rd_in_range;
    logic [14:0]   rd_addr;

    logic          wr_pend;
    logic [14:0]   wr_addr;
    logic [CW-1:0] wr_colour;

    // Decode range and addresses for the plot and read ports.
    always_comb begin
        plot_in_range = ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);
        plot_accept   = vga_plot && plot_in_range;
        plot_clip     = vga_plot && !plot_in_range;
        plot_addr     = pix_addr(vga_x, vga_y);
        rd_in_range   = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
        rd_addr       = pix_addr(rd_x, rd_y);
    end

    // Write pipeline register: an accepted plot is committed to memory one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            wr_colour <= '0;
        end else begin
            wr_pend <= plot_accept;
            if (plot_accept) begin
                wr_addr   <= plot_addr;
                wr_colour <= vga_colour;
            end
        end
    end

    // Frame store write; contents survive reset, and a write pending at reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_pend)
            mem[wr_addr] <= wr_colour;
    end

    // Read port: newest data wins, same-cycle plot first, then the pending write, then memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_colour <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (!rd_in_range)
                    rd_colour <= '0;
                else if (plot_accept && (plot_addr == rd_addr))
                    rd_colour <= vga_colour;
                else if (wr_pend && (wr_addr == rd_addr))
                    rd_colour <= wr_colour;
                else
                    rd_colour <= mem[rd_addr];
            end
        end
    end

    // Saturating counters and sticky frame_done; clr_cnt beats any same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plot_count <= '0;
            clip_count <= '0;
            frame_done <= 1'b0;
        end else if (clr_cnt) begin
            plot_count <= '0;
            clip_count <= '0;
            frame_done <= 1'b0;
        end else begin
            if (plot_accept && (plot_count != PLOT_MAX))
                plot_count <= plot_count + 15'd1;
            if (plot_clip && (clip_count != CLIP_MAX))
                clip_count <= clip_count + 8'd1;
            if (plot_count >= FRAME_PIXELS)
                frame_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed bench for plot_framebuffer: reset, single plot/readback, bypass,
// clipping, full-frame stream, saturation, clear priority, mid-stream reset.
module tb_plot_framebuffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  vga_x = '0;
    logic [6:0]  vga_y = '0;
    logic [2:0]  vga_colour = '0;
    logic        vga_plot = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_x = '0;
    logic [6:0]  rd_y = '0;
    logic [2:0]  rd_colour;
    logic        rd_valid;
    logic        clr_cnt = 1'b0;
    logic [14:0] plot_count;
    logic [7:0]  clip_count;
    logic        frame_done;

    int n_compared = 0;
    int n_mismatched = 0;

    plot_framebuffer #(.WIDTH(160), .HEIGHT(120), .CW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .rd_en      (rd_en),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_colour  (rd_colour),
        .rd_valid   (rd_valid),
        .clr_cnt    (clr_cnt),
        .plot_count (plot_count),
        .clip_count (clip_count),
        .frame_done (frame_done)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic plot(input int x, input int y, input int c);
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(c);
        vga_plot   = 1'b1;
    endtask

    task automatic read_req(input int x, input int y);
        rd_x  = 8'(x);
        rd_y  = 7'(y);
        rd_en = 1'b1;
    endtask

    task automatic idle();
        vga_plot = 1'b0;
        rd_en    = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    initial begin
        // Reset: outputs drop asynchronously.
        #2 rst_n = 1'b0;
        #1;
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_colour", 32'(rd_colour), 0);
        check("rst_plot_count", 32'(plot_count), 0);
        check("rst_clip_count", 32'(clip_count), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_rd_valid", 32'(rd_valid), 0);

        // Idle read at (0,0): valid one cycle later, then low again.
        read_req(0, 0);
        tick();
        idle();
        check("read00_valid", 32'(rd_valid), 1);
        tick();
        check("read00_valid_drop", 32'(rd_valid), 0);

        // Single plot then readback two cycles later.
        plot(2, 17, 2);
        tick();
        idle();
        check("single_plot_count", 32'(plot_count), 1);
        tick();
        read_req(2, 17);
        tick();
        idle();
        check("single_rd_colour", 32'(rd_colour), 2);
        check("single_rd_valid", 32'(rd_valid), 1);

        // Same-cycle collision.
        plot(5, 5, 7);
        read_req(5, 5);
        tick();
        idle();
        check("coll_same_colour", 32'(rd_colour), 7);
        check("coll_same_count", 32'(plot_count), 2);

        // Collision with the pending pipelined write.
        plot(6, 6, 3);
        tick();
        idle();
        read_req(6, 6);
        tick();
        idle();
        check("coll_pend_colour", 32'(rd_colour), 3);
        check("coll_pend_count", 32'(plot_count), 3);

        // Known value at (0,0), then three clipped plots.
        plot(0, 0, 5);
        tick();
        plot(160, 0, 1);
        tick();
        plot(0, 120, 1);
        tick();
        plot(255, 127, 1);
        tick();
        idle();
        check("clip_count3", 32'(clip_count), 3);
        check("clip_plot_count", 32'(plot_count), 4);

        // Out-of-range read returns 0, valid.
        read_req(200, 5);
        tick();
        idle();
        check("oor_rd_colour", 32'(rd_colour), 0);
        check("oor_rd_valid", 32'(rd_valid), 1);
        read_req(0, 0);
        tick();
        idle();
        check("clip_read00", 32'(rd_colour), 5);
        tick();
        check("hold_rd_valid", 32'(rd_valid), 0);
        check("hold_rd_colour", 32'(rd_colour), 5);

        // Strobe low with in-range coordinates: no count change.
        vga_x = 8'd9; vga_y = 7'd9; vga_colour = 3'd6;
        tick();
        check("noplot_count", 32'(plot_count), 4);
        read_req(0, 0);
        tick();
        idle();
        check("noplot_read00", 32'(rd_colour), 5);

        // Clear alone.
        clr_cnt = 1'b1;
        tick();
        idle();
        check("clr_plot_count", 32'(plot_count), 0);
        check("clr_clip_count", 32'(clip_count), 0);

        // Full column-major frame, colour = x mod 8.
        for (int x = 0; x < 160; x++) begin
            for (int y = 0; y < 120; y++) begin
                plot(x, y, x % 8);
                tick();
            end
        end
        idle();
        check("full_plot_count", 32'(plot_count), 19200);
        check("full_frame_done_early", 32'(frame_done), 0);
        tick();
        check("full_frame_done", 32'(frame_done), 1);
        read_req(2, 21);
        tick();
        idle();
        check("full_read_2_21", 32'(rd_colour), 2);
        read_req(159, 119);
        tick();
        idle();
        check("full_read_159_119", 32'(rd_colour), 7);

        // Drive plot_count into saturation: 13567 more reaches 32767.
        for (int i = 0; i < 13570; i++) begin
            plot(10, 10, 0);
            tick();
        end
        idle();
        check("plot_sat", 32'(plot_count), 32767);
        check("sat_frame_done", 32'(frame_done), 1);

        // Clip counter saturation.
        for (int i = 0; i < 260; i++) begin
            plot(200, 3, 1);
            tick();
        end
        idle();
        check("clip_sat", 32'(clip_count), 255);

        // Clear in the same cycle as a plot: clear wins, write still lands.
        clr_cnt = 1'b1;
        plot(1, 1, 4);
        tick();
        idle();
        check("clrplot_count", 32'(plot_count), 0);
        check("clrplot_frame_done", 32'(frame_done), 0);
        check("clrplot_clip", 32'(clip_count), 0);
        tick();
        read_req(1, 1);
        tick();
        idle();
        check("clrplot_read_1_1", 32'(rd_colour), 4);

        // Reset mid-stream with a write pending and a read just returned.
        plot(3, 3, 6);
        read_req(1, 1);
        tick();
        idle();
        check("pre_rst_valid", 32'(rd_valid), 1);
        check("pre_rst_count", 32'(plot_count), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rd_valid", 32'(rd_valid), 0);
        check("midrst_rd_colour", 32'(rd_colour), 0);
        check("midrst_plot_count", 32'(plot_count), 0);
        check("midrst_frame_done", 32'(frame_done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        read_req(3, 3);
        tick();
        idle();
        check("dropped_write_3_3", 32'(rd_colour), 3);
        read_req(1, 1);
        tick();
        idle();
        check("kept_mem_1_1", 32'(rd_colour), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/plot_framebuffer.md
Name: plot_framebuffer

Overview:
Downstream consumer of the fillscreen pixel-plot stream (vga_x/vga_y/vga_colour/vga_plot). It captures every in-range plot into an on-chip WIDTH×HEIGHT frame store with 3-bit colour, and counts written and clipped pixels. It provides a read port so a scan-out or self-check stage can read back any pixel. It sits between the drawing engines (fillscreen, later circle) and the display/check logic.

Parameters:
WIDTH, 160, frame width in pixels
HEIGHT, 120, frame height in pixels
CW, 3, colour width in bits

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
vga_x  in  8  plot x coordinate
vga_y  in  7  plot y coordinate
vga_colour  in  CW  plot colour
vga_plot  in  1  plot strobe; one pixel per cycle while high
rd_en  in  1  read request
rd_x  in  8  read x coordinate
rd_y  in  7  read y coordinate
rd_colour  out  CW  read data
rd_valid  out  1  rd_colour valid, one cycle after rd_en
clr_cnt  in  1  synchronous clear of counters and frame_done
plot_count  out  15  accepted in-range writes since reset/clear, saturating at 32767
clip_count  out  8  rejected out-of-range plots, saturating at 255
frame_done  out  1  sticky flag: plot_count has reached WIDTH*HEIGHT

Behaviour:
- Reset: asynchronous on rst_n low. rd_colour=0, rd_valid=0, plot_count=0, clip_count=0, frame_done=0, write pipeline register cleared. Frame memory contents are not reset.
- Address: addr = y*WIDTH + x, computed in 15 bits. Multiplication by 160 is implemented as (y<<7)+(y<<5).
- Write path has a 1-cycle pipeline:
  - Cycle N: vga_plot is sampled. If x<WIDTH and y<HEIGHT, addr and colour are registered.
  - Cycle N+1: memory is written.
  - If out of range, nothing is written and clip_count increments (saturating).
- plot_count increments in cycle N for each in-range plot, including rewrites of the same pixel. It saturates at 32767.
- frame_done sets in the cycle after plot_count reaches WIDTH*HEIGHT (19200). It stays high until clr_cnt or reset.
- Read path:
  - rd_en is sampled at cycle N; rd_colour and rd_valid are driven at N+1.
  - rd_valid is low in any cycle not following an rd_en.
  - rd_colour holds its last value when rd_valid is low.
  - Out-of-range read coordinates return rd_colour=0 with rd_valid=1.
- Read/write collision: if the read address equals the pending pipelined write address, or the address being plotted in the same cycle N, the read returns the new colour (write-first bypass).
- clr_cnt clears plot_count, clip_count and frame_done at the next edge.
  - clr_cnt has priority over a simultaneous increment: the result is 0, not 1.
  - clr_cnt does not touch memory or the write pipeline.
- Reset mid-stream: a pending pipelined write is dropped. Memory keeps earlier contents.
- No backpressure: the block accepts one plot every cycle indefinitely.
- vga_plot low: no write and no count change. Coordinate and colour inputs are ignored.

Test Plan:
- Reset then idle: rd_en with (0,0) -> rd_valid=1 one cycle later; all counters 0; frame_done=0.
- Single plot (x=2, y=17, colour=2), then rd_en at (2,17) two cycles later -> rd_colour=2, rd_valid=1; plot_count=1.
- Collision: plot (5,5,colour 7) and rd_en at (5,5) in the same cycle -> rd_colour=7 next cycle.
- Clipping: plots at (160,0), (0,120), (255,127) -> clip_count=3; plot_count unchanged; reading (0,0) returns the prior value.
- Full fillscreen-style stream (column-major, colour=x mod 8, 19200 consecutive plots):
  - frame_done rises one cycle after the last plot; plot_count=19200.
  - Reading (2,21) gives 2; reading (159,119) gives 7.
- clr_cnt asserted in the same cycle as a plot -> plot_count=0 and frame_done=0 afterwards. Then assert rst_n low during the stream -> all outputs 0 immediately, without waiting for a clock edge.
